// File: rtl/calc_btn_cond_if.sv
// Button/switch bundle between the board pins and the calculator core.
// Raw btn_in/sw_in in; debounced btn_lvl/btn_pulse and synced sw_out out.
interface calc_btn_cond_if;
  logic [4:0]  btn_in;
  logic [0:15] sw_in;
  logic [4:0]  btn_lvl;
  logic [4:0]  btn_pulse;
  logic [0:15] sw_out;

  modport master (
    output btn_in, sw_in,
    input  btn_lvl, btn_pulse, sw_out
  );

  modport slave (
    input  btn_in, sw_in,
    output btn_lvl, btn_pulse, sw_out
  );
endinterface

// File: rtl/calc_btn_cond.sv
// Sync + debounce of 5 push-buttons, 2-flop sync of 16 switches.
// Ports: clk, rst_n (async low), bus (slave: btn_in/sw_in -> btn_lvl/btn_pulse/sw_out).
module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  calc_btn_cond_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]         s1_q, s2_q;
  logic [4:0]         lvl_q, lvl_d;
  logic [4:0]         pulse_q, pulse_d;
  logic [4:0][CW-1:0] cnt_q, cnt_d;
  logic [0:15]        sw1_q, sw2_q;

  // Pulse is registered alongside the accepting edge, so it
  // coincides with the cycle in which lvl first reads 1.
  always_comb begin
    lvl_d   = lvl_q;
    pulse_d = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != LAST) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        lvl_d[i]   = s2_q[i];
        pulse_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
    end else begin
      s1_q    <= bus.btn_in;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      sw1_q   <= bus.sw_in;
      sw2_q   <= sw1_q;
    end
  end

  assign bus.btn_lvl   = lvl_q;
  assign bus.btn_pulse = pulse_q;
  assign bus.sw_out    = sw2_q;

endmodule

// File: tb/tb_calc_btn_cond.sv
// Bench for calc_btn_cond with DEBOUNCE_CYCLES=4.
// Directed plan scenarios followed by random toggling vs a window model.
module tb_calc_btn_cond;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_btn_cond_if bus();

  calc_btn_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vec = 0;
  int bad = 0;

  // Model: history of raw samples per edge. A button flips when the
  // last N values seen by the second sync flop all disagree with it.
  logic [4:0]  hist[$];
  logic [0:15] swh[$];
  logic [4:0]  m_lvl, m_pulse;
  logic [0:15] m_sw;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    hist.push_back(5'h0);
    hist.push_back(5'h0);
    swh.delete();
    swh.push_back(16'h0);
    m_lvl = '0;
    m_pulse = '0;
    m_sw = '0;
  endfunction

  task automatic step();
    logic [4:0]  r;
    logic [0:15] s;
    bit all;
    @(posedge clk);
    r = bus.btn_in;
    s = bus.sw_in;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back(r);
      m_pulse = '0;
      if (hist.size() >= N + 2) begin
        for (int i = 0; i < 5; i++) begin
          all = 1'b1;
          for (int j = 0; j < N; j++)
            if (hist[hist.size()-3-j][i] == m_lvl[i]) all = 1'b0;
          if (all) begin
            m_lvl[i] = ~m_lvl[i];
            m_pulse[i] = m_lvl[i];
          end
        end
      end
      if (hist.size() > 40) void'(hist.pop_front());
      swh.push_back(s);
      m_sw = swh[swh.size()-2];
      if (swh.size() > 8) void'(swh.pop_front());
    end
    #1;
    chk("lvl", {11'h0, bus.btn_lvl}, {11'h0, m_lvl});
    chk("pulse", {11'h0, bus.btn_pulse}, {11'h0, m_pulse});
    chk("sw", bus.sw_out, m_sw);
  endtask

  // Runs n edges; first edge is edge 0. Reports pulse count and
  // the edge of the first pulse for button idx.
  task automatic run(input int n, input int idx,
                     output int pulses, output int first);
    pulses = 0;
    first = -1;
    for (int e = 0; e < n; e++) begin
      step();
      if (bus.btn_pulse[idx]) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
  endtask

  int pc, fe;
  logic [4:0] b;

  initial begin
    model_reset();
    bus.btn_in = 5'h1F;
    bus.sw_in = 16'hFFFF;
    for (int k = 0; k < 3; k++) step();
    chk("rst_lvl", {11'h0, bus.btn_lvl}, 16'h0);
    chk("rst_sw", bus.sw_out, 16'h0);
    bus.btn_in = '0;
    bus.sw_in = '0;
    rst_n = 1'b1;
    run(8, 0, pc, fe);

    // clean press of btnd, then long hold
    bus.btn_in = 5'h10;
    run(106, 4, pc, fe);
    chk("btnd_first", 16'(fe), 16'd5);
    chk("btnd_count", 16'(pc), 16'd1);
    chk("btnd_lvl", {15'h0, bus.btn_lvl[4]}, 16'h1);

    // bounce on btnc, shorter than the debounce window
    pc = 0;
    for (int t = 0; t < 4; t++) begin
      bus.btn_in[0] = (t % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step();
        if (bus.btn_pulse[0] || bus.btn_lvl[0]) pc++;
      end
    end
    chk("bounce_quiet", 16'(pc), 16'd0);
    bus.btn_in[0] = 1'b1;
    run(20, 0, pc, fe);
    chk("bounce_first", 16'(fe), 16'd5);
    chk("bounce_count", 16'(pc), 16'd1);

    // release of btnu
    bus.btn_in[2] = 1'b1;
    run(10, 2, pc, fe);
    bus.btn_in[2] = 1'b0;
    run(10, 2, pc, fe);
    chk("rel_pulse", 16'(pc), 16'd0);
    chk("rel_lvl", {15'h0, bus.btn_lvl[2]}, 16'h0);

    // simultaneous press
    bus.btn_in = '0;
    run(10, 0, pc, fe);
    bus.btn_in = 5'h1F;
    for (int e = 0; e < 8; e++) begin
      step();
      if (e == 4) chk("sim_e4", {11'h0, bus.btn_pulse}, 16'h0);
      if (e == 5) chk("sim_e5", {11'h0, bus.btn_pulse}, 16'h1F);
      if (e == 6) chk("sim_e6", {11'h0, bus.btn_pulse}, 16'h0);
    end

    // switch latency
    bus.sw_in = 16'hA5C3;
    step();
    chk("sw_e0", bus.sw_out, 16'h0);
    step();
    chk("sw_e1", bus.sw_out, 16'hA5C3);

    // asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lvl", {11'h0, bus.btn_lvl}, 16'h0);
    chk("arst_sw", bus.sw_out, 16'h0);
    model_reset();
    step();
    rst_n = 1'b1;
    bus.btn_in = '0;
    run(10, 1, pc, fe);

    // reset while btnl is part-way through its count
    bus.btn_in = 5'h02;
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    run(20, 1, pc, fe);
    chk("rstmid_first", 16'(fe), 16'd5);
    chk("rstmid_count", 16'(pc), 16'd1);

    // random toggling with occasional reset
    for (int k = 0; k < 800; k++) begin
      b = bus.btn_in;
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      bus.btn_in = b;
      if ($urandom_range(0, 3) == 0) bus.sw_in = 16'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/calc_btn_cond.md
# calc_btn_cond

Input conditioning stage that sits directly upstream of the calculator core. It takes the five raw board push-buttons and the 16 slide switches, synchronises them into the `clk` domain, and debounces each button. For each button it produces a clean level and a one-cycle press pulse, so the calculator sees glitch-free `btnc/btnl/btnu/btnr/btnd` and a stable `sw` bus.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000 — consecutive synchronised cycles a button must hold a new value before it is accepted; legal range ≥ 2. The default gives 10 ms at 100 MHz. Internal counter width is derived to hold `DEBOUNCE_CYCLES-1`.
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `btn_in`  in  5  — raw buttons, asynchronous. Bit map: [0] btnc, [1] btnl, [2] btnu, [3] btnr, [4] btnd.
- `sw_in`  in  [0:15]  — raw slide switches, asynchronous.
- `btn_lvl`  out  5  — debounced button level, same bit map.
- `btn_pulse`  out  5  — one-cycle pulse on each debounced 0→1 transition, same bit map.
- `sw_out`  out  [0:15]  — switches after the 2-flop synchroniser.

## Operation
- **Synchroniser**
  - Each `btn_in` bit passes through 2 flops: `s1`, then `s2`.
  - `sw_in` passes through 2 flops to `sw_out`. Switches are not debounced.
- **Per-button debouncer**, 5 identical independent instances, each with state `lvl` and counter `cnt`:
  - If `s2 == lvl`, then `cnt <= 0`.
  - If `s2 != lvl` and `cnt != DEBOUNCE_CYCLES-1`, then `cnt <= cnt+1`.
  - If `s2 != lvl` and `cnt == DEBOUNCE_CYCLES-1`, then `lvl <= s2` and `cnt <= 0`.
  - Any cycle with `s2 == lvl` resets the count. A glitch shorter than `DEBOUNCE_CYCLES` consecutive cycles at `s2` never changes `lvl`.
- **Press pulse**
  - `btn_pulse[i]` is registered. It is 1 for exactly the cycle after the edge on which `lvl[i]` goes 0→1, and 0 otherwise.
  - A release (1→0) produces no pulse.
  - A held button produces exactly one pulse, however long it is held.
- **Simultaneous events**: buttons are fully independent. Several pulses may assert on the same cycle.
- **Reset**
  - While `rst_n` = 0, all flops are 0: `s1`, `s2`, `lvl`, `cnt`, `btn_pulse`, and the `sw` sync flops.
  - Therefore the reset value of `btn_lvl`, `btn_pulse` and `sw_out` is 0.
  - Reset is asserted asynchronously. It is released with no special handling.
- **Reset mid-operation**: a partially counted debounce is discarded. A button still held when `rst_n` rises is treated as a new press and yields one pulse after the full latency.

## Timing
- Button press latency. Call edge 0 the first `clk` edge that samples the new raw value into `s1`.
  - `s2` updates at edge 1.
  - `cnt` counts on edges 2 … N, where N = `DEBOUNCE_CYCLES`.
  - `btn_lvl` and `btn_pulse` rise after edge N+1.
  - `btn_pulse` falls after edge N+2.
- Release latency is identical: `btn_lvl` falls after edge N+1, with no pulse.
- A bounce that restores `s2 == lvl` at any edge before the accepting edge restarts the full N-cycle count from the next mismatch.
- `sw_out` latency: 2 edges.
- Outputs are all registered. No combinational path exists from any input to any output.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` unless stated.
- **Reset values**: hold `rst_n`=0 with `btn_in`=5'h1F and `sw_in`=16'hFFFF → `btn_lvl`=0, `btn_pulse`=0, `sw_out`=0 throughout. Asserting `rst_n` asynchronously mid-cycle clears all outputs without waiting for a clock edge.
- **Clean press of btnd**: `btn_in[4]` goes 0→1 and holds. Take the first sampling edge as edge 0.
  - `btn_lvl[4]`=1 and `btn_pulse[4]`=1 after edge 5.
  - `btn_pulse[4]`=0 after edge 6.
  - Holding for 100 cycles produces no further pulse.
- **Bounce rejection**: `btn_in[0]` toggles 1,0,1,0 at 3-cycle intervals, then stays 1.
  - No output change during the toggling.
  - Exactly one pulse occurs, 5 edges after the final sampled 0→1.
- **Release**: from a debounced-high state, drop `btn_in[2]` → `btn_lvl[2]`=0 after edge 5, and `btn_pulse` stays 0.
- **Simultaneous presses**: `btn_in` 0→5'h1F in one cycle → all 5 `btn_pulse` bits assert on the same cycle, for one cycle.
- **Reset mid-count and switches**:
  - Assert `rst_n` while `cnt[1]`=2 during a btnl press, then release reset with the button held → exactly one pulse, 5 edges after the first post-reset sampling edge.
  - `sw_in`=16'hA5C3 → `sw_out`=16'hA5C3 after 2 edges.
